// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory / MMIO port between the
// CPU load/store path and an aux master (debug/DMA).
//   - Fixed CPU priority, but the aux master wins after MAX_BURST consecutive
//     CPU grants taken while it was waiting.
//   - Each accepted read is tagged with its owner and the tag travels down a
//     RD_LATENCY-deep pipe, so the shared read data is qualified by exactly
//     one *_rvalid when it comes back.
// Optional feature: define ARB_STATS_EN to enable the grant/stall counters;
// without it the stat ports are tied to zero.
//
// Handshake: a requester raises *_req with stable *_we/*_addr/*_wdata and
// holds them until *_gnt is seen high in the same cycle; that cycle is the
// access. Dropping *_req before a grant is legal and leaves no trace. Reads
// answer with *_rvalid RD_LATENCY cycles later; writes have no response.
module dmem_port_arbiter #(
    parameter int DBITS      = 32,
    parameter int ABITS      = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cpu_req,
    input  logic             i_cpu_we,
    input  logic [ABITS-1:0] i_cpu_addr,
    input  logic [DBITS-1:0] i_cpu_wdata,
    output logic             o_cpu_gnt,
    output logic             o_cpu_rvalid,
    input  logic             i_aux_req,
    input  logic             i_aux_we,
    input  logic [ABITS-1:0] i_aux_addr,
    input  logic [DBITS-1:0] i_aux_wdata,
    output logic             o_aux_gnt,
    output logic             o_aux_rvalid,
    output logic [DBITS-1:0] o_rdata,
    output logic             o_mem_en,
    output logic             o_mem_we,
    output logic [ABITS-1:0] o_mem_addr,
    output logic [DBITS-1:0] o_mem_wdata,
    input  logic [DBITS-1:0] i_mem_rdata,
    output logic [15:0]      o_stat_cpu,
    output logic [15:0]      o_stat_aux,
    output logic [15:0]      o_stat_stall
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    logic [3:0]            r_burst_cnt;
    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [RD_LATENCY-1:0] r_pipe_own;   // 1 = aux owns the read, 0 = CPU

    logic w_cpu_wins;
    logic w_cpu_gnt;
    logic w_aux_gnt;
    logic w_mem_we;
    logic w_rd_push;

    // Grant decision: CPU wins unless the aux master is waiting and the CPU
    // has already used up its burst allowance. Nothing is granted in reset.
    always_comb begin
        w_cpu_wins = i_cpu_req & (~i_aux_req | (r_burst_cnt < MAX_B));
        w_cpu_gnt  = i_reset & w_cpu_wins;
        w_aux_gnt  = i_reset & i_aux_req & ~w_cpu_wins;
        w_mem_we   = w_aux_gnt ? i_aux_we : (w_cpu_gnt & i_cpu_we);
        w_rd_push  = (w_cpu_gnt | w_aux_gnt) & ~w_mem_we;
    end

    assign o_cpu_gnt   = w_cpu_gnt;
    assign o_aux_gnt   = w_aux_gnt;
    assign o_mem_en    = w_cpu_gnt | w_aux_gnt;
    assign o_mem_we    = w_mem_we;
    // When idle the CPU fields are presented; mem_en qualifies them.
    assign o_mem_addr  = w_aux_gnt ? i_aux_addr  : i_cpu_addr;
    assign o_mem_wdata = w_aux_gnt ? i_aux_wdata : i_cpu_wdata;
    assign o_rdata     = i_mem_rdata;

    // Anti-starvation counter: counts CPU wins only while aux is waiting,
    // restarts whenever aux is served or stops asking, saturates at MAX_BURST.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_burst_cnt <= 4'd0;
        end else if (w_aux_gnt || !i_aux_req) begin
            r_burst_cnt <= 4'd0;
        end else if (w_cpu_gnt && (r_burst_cnt < MAX_B)) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

    // Read tag pipe: stage 0 captures the read accepted this cycle, the last
    // stage lines up with the memory's read data. Reset drops all tags.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pipe_vld <= '0;
            r_pipe_own <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_push;
            r_pipe_own[0] <= w_aux_gnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_own[i] <= r_pipe_own[i-1];
            end
        end
    end

    assign o_cpu_rvalid = i_reset & r_pipe_vld[RD_LATENCY-1] & ~r_pipe_own[RD_LATENCY-1];
    assign o_aux_rvalid = i_reset & r_pipe_vld[RD_LATENCY-1] &  r_pipe_own[RD_LATENCY-1];

`ifdef ARB_STATS_EN
    logic [15:0] r_stat_cpu;
    logic [15:0] r_stat_aux;
    logic [15:0] r_stat_stall;
    logic        w_stall;

    assign w_stall = (i_cpu_req & ~w_cpu_gnt) | (i_aux_req & ~w_aux_gnt);

    // Saturating grant and stall counters.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_stat_cpu   <= 16'd0;
            r_stat_aux   <= 16'd0;
            r_stat_stall <= 16'd0;
        end else begin
            if (w_cpu_gnt && (r_stat_cpu != 16'hFFFF)) begin
                r_stat_cpu <= r_stat_cpu + 16'd1;
            end
            if (w_aux_gnt && (r_stat_aux != 16'hFFFF)) begin
                r_stat_aux <= r_stat_aux + 16'd1;
            end
            if (w_stall && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign o_stat_cpu   = r_stat_cpu;
    assign o_stat_aux   = r_stat_aux;
    assign o_stat_stall = r_stat_stall;
`else
    assign o_stat_cpu   = 16'd0;
    assign o_stat_aux   = 16'd0;
    assign o_stat_stall = 16'd0;
`endif

endmodule
